fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 clk  input  1  rising-edge clock; one clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  downstream decode cannot accept; hold the IF/ID register.
REQ-005 redirect  input  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-006 redirect_pc  input  32  byte address of the redirect target.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  request byte address, word aligned.
REQ-009 imem_ready  input  1  memory accepts the request; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr  output  32  IF/ID instruction, feeds the decode stage.
REQ-012 pc_out  output  32  IF/ID address of instr.
REQ-013 pc_plus4  output  32  pc_out + 4, used as the jal link value.
REQ-014 instr_valid  output  1  IF/ID holds a live instruction.

Function
REQ-015 FSM states: IDLE, FETCH, DISCARD, HOLD; FETCH_ADDR register fa; skid register; pending-target register.
REQ-016 IDLE: imem_req=0; moves to FETCH on the first edge after rst_n deasserts.
REQ-017 FETCH/DISCARD: imem_req=1, imem_addr=fa; imem_addr is stable until imem_ready=1 and never changes mid-request.
REQ-018 FETCH on ready, redirect=0, (stall=0 or instr_valid=0): IF/ID <= {imem_rdata, fa}, instr_valid<=1, fa<=fa+4, stay in FETCH.
REQ-019 FETCH on ready, redirect=0, stall=1, instr_valid=1: word goes to skid, fa<=fa+4, go to HOLD.
REQ-020 FETCH on ready with redirect=1: drop the word, fa<=redirect_pc, stay in FETCH.
REQ-021 FETCH with no ready and redirect=1: pending<=redirect_pc, go to DISCARD.
REQ-022 DISCARD: a new redirect overwrites pending; on ready, drop the word, fa<=pending (or redirect_pc if redirect is asserted that cycle), go to FETCH.
REQ-023 HOLD: imem_req=0; stall=0 moves skid to IF/ID and goes to FETCH.
REQ-024 HOLD with redirect=1: drop skid, fa<=redirect_pc, go to FETCH; redirect takes priority over stall.
REQ-025 Redirect in any state: next edge instr<=32'h0000_0000 (NOP), instr_valid<=0, regardless of stall.
REQ-026 stall=1, instr_valid=1, redirect=0: instr, pc_out and instr_valid hold their values.
REQ-027 stall=0 with no word captured: instr_valid<=0, instr<=NOP.
REQ-028 Zero-wait memory (imem_ready always 1) gives one instruction per cycle; first instr_valid two edges after reset release.
REQ-029 Address arithmetic is modulo 2^32; fa=32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-030 rst_n=0 asynchronously forces state=IDLE, fa=RESET_PC, instr=NOP, pc_out=0, instr_valid=0, imem_req=0, skid=0, pending=0.
REQ-031 Reset asserted mid-request abandons the request; the next ready is ignored until FETCH is re-entered.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN defined: adds output fetch_misalign (1 bit, reset 0).
REQ-033 With the macro, a redirect with redirect_pc[1:0]!=0 sets fetch_misalign sticky until reset, forces state IDLE, and issues no further requests.
REQ-034 Without the macro, the port does not exist and redirect_pc[1:0] are treated as 2'b00.

Structure
REQ-035 Shared package mips_pkg holds NOP_INSTR, the RESET_PC default and the fetch_state_t enum.
REQ-036 The single sub-module ifid_reg holds instr/pc_out/instr_valid with load, hold and flush controls.

Verification
REQ-037 Reset release, imem_ready=1, imem_rdata=addr-tagged words -> imem_addr 0,4,8,12 on consecutive cycles; pc_out follows one cycle later.
REQ-038 imem_ready low for 3 cycles at addr 8 -> imem_addr stays 8 for all 4 cycles; instr_valid=0 in the gaps.
REQ-039 stall=1 for 4 cycles with zero-wait memory -> one word in skid, imem_req=0 in HOLD; after release pc_out sequence continues with no gap or duplicate.
REQ-040 redirect=1, redirect_pc=32'h40 during a pending request at 0x10 -> word from 0x10 dropped; next imem_addr=0x40; instr_valid=0 for the flush cycle.
REQ-041 redirect and stall asserted together -> instr=NOP, instr_valid=0 next edge; next fetch at redirect_pc.
REQ-042 With FETCH_ALIGN_CHECK_EN, redirect_pc=32'h42 -> fetch_misalign=1, imem_req=0 until rst_n pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default reset PC and the fetch FSM states.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDiscard,
    StHold
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus; ready doubles as the same-cycle read-data valid.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority: flush, load, hold; otherwise a bubble is inserted.
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (!i_hold) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with skid buffer and redirect handling.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_misalign output that halts fetch.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic [31:0]         pc_out,
  output logic [31:0]         pc_plus4,
  output logic                instr_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                fetch_misalign
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_fa;
  logic [31:0]  r_skid_instr;
  logic [31:0]  r_skid_pc;
  logic [31:0]  r_pending;
  logic         r_req;

  logic [31:0]  w_redirect_tgt;
  logic         w_misalign_redirect;
  logic         w_halt;
  logic         w_fetch_load;
  logic         w_skid_load;
  logic         w_load;
  logic         w_hold;
  logic [31:0]  w_load_instr;
  logic [31:0]  w_load_pc;

  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign_redirect = redirect & (redirect_pc[1:0] != 2'b00);
  assign w_halt              = r_misalign;
  assign fetch_misalign      = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (w_misalign_redirect) begin
      r_misalign <= 1'b1;
    end
  end
`else
  assign w_misalign_redirect = 1'b0;
  assign w_halt              = 1'b0;
`endif

  // The request is held in the register so imem_addr cannot move until ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_fa         <= RESET_PC;
      r_skid_instr <= 32'h0000_0000;
      r_skid_pc    <= 32'h0000_0000;
      r_pending    <= 32'h0000_0000;
      r_req        <= 1'b0;
    end else if (w_misalign_redirect) begin
      r_state <= StIdle;
      r_req   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (redirect) begin
            r_fa <= w_redirect_tgt;
          end
          if (!w_halt) begin
            r_state <= StFetch;
            r_req   <= 1'b1;
          end
        end
        StFetch: begin
          if (imem.imem_ready) begin
            if (redirect) begin
              r_fa <= w_redirect_tgt;
            end else begin
              r_fa <= r_fa + 32'd4;
              if (stall && instr_valid) begin
                r_skid_instr <= imem.imem_rdata;
                r_skid_pc    <= r_fa;
                r_state      <= StHold;
                r_req        <= 1'b0;
              end
            end
          end else if (redirect) begin
            r_pending <= w_redirect_tgt;
            r_state   <= StDiscard;
          end
        end
        StDiscard: begin
          if (imem.imem_ready) begin
            r_fa    <= redirect ? w_redirect_tgt : r_pending;
            r_state <= StFetch;
          end else if (redirect) begin
            r_pending <= w_redirect_tgt;
          end
        end
        StHold: begin
          if (redirect) begin
            r_fa    <= w_redirect_tgt;
            r_state <= StFetch;
            r_req   <= 1'b1;
          end else if (!stall) begin
            r_state <= StFetch;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_fetch_load = (r_state == StFetch) && imem.imem_ready && !redirect &&
                   (!stall || !instr_valid);
    w_skid_load  = (r_state == StHold) && !redirect && !stall;
    w_load       = w_fetch_load || w_skid_load;
    w_hold       = stall && instr_valid;
    w_load_instr = w_skid_load ? r_skid_instr : imem.imem_rdata;
    w_load_pc    = w_skid_load ? r_skid_pc : r_fa;
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_hold  (w_hold),
    .i_flush (redirect),
    .i_instr (w_load_instr),
    .i_pc    (w_load_pc),
    .o_instr (instr),
    .o_pc    (pc_out),
    .o_valid (instr_valid)
  );

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_fa;
  assign pc_plus4       = pc_out + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, wait states, stall/skid, redirects, wrap, reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int n_total;
  int n_bad;

  fetch_unit_if bus ();

  // Memory returns an address-tagged word.
  assign bus.imem_rdata = bus.imem_addr ^ 32'hC0DE_0000;

  fetch_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_live(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check_eq({tag, "_pc"}, pc_out, pc);
    check_eq({tag, "_instr"}, instr, word_at(pc));
    check_eq({tag, "_pc4"}, pc_plus4, pc + 32'd4);
  endtask

  task automatic expect_bubble(input string tag);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check_eq({tag, "_nop"}, instr, 32'h0000_0000);
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    bus.imem_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_addr", bus.imem_addr, 32'h0);
    check_eq("rst_pc", pc_out, 32'h0);
    expect_bubble("rst");

    // Zero-wait streaming.
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_exit_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("idle_exit_addr", bus.imem_addr, 32'h0);
    expect_bubble("first_gap");
    @(negedge clk);
    expect_live("s0", 32'h0);
    check_eq("s0_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    expect_live("s1", 32'h4);
    check_eq("s1_addr", bus.imem_addr, 32'h8);

    // Three wait states at address 8.
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("wait_addr", bus.imem_addr, 32'h8);
      check_eq("wait_req", {31'd0, bus.imem_req}, 32'd1);
      expect_bubble("wait");
    end
    bus.imem_ready = 1'b1;
    @(negedge clk);
    expect_live("after_wait", 32'h8);
    check_eq("after_wait_addr", bus.imem_addr, 32'hC);

    // Four-cycle stall: word 0xC parks in the skid, no requests while holding.
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_live("stall", 32'h8);
      check_eq("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    expect_live("skid_out", 32'hC);
    check_eq("skid_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("skid_addr", bus.imem_addr, 32'h10);

    // Redirect while the request at 0x10 is waiting.
    bus.imem_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    expect_bubble("flush");
    check_eq("discard_addr", bus.imem_addr, 32'h10);
    redirect       = 1'b0;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    check_eq("redir_addr", bus.imem_addr, 32'h40);
    expect_bubble("dropped");
    @(negedge clk);
    expect_live("redir_word", 32'h40);

    // Redirect together with stall: redirect wins.
    redirect    = 1'b1;
    stall       = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    expect_bubble("rs_flush");
    check_eq("rs_addr", bus.imem_addr, 32'h100);
    redirect = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    expect_live("rs_word", 32'h100);

    // Second redirect during DISCARD overwrites the pending target.
    bus.imem_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    check_eq("disc1_addr", bus.imem_addr, 32'h104);
    redirect_pc = 32'h300;
    @(negedge clk);
    check_eq("disc2_addr", bus.imem_addr, 32'h104);
    expect_bubble("disc2");
    redirect       = 1'b0;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    check_eq("pend_addr", bus.imem_addr, 32'h300);
    @(negedge clk);
    expect_live("pend_word", 32'h300);

    // Address wrap at the top of the space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    check_eq("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    @(negedge clk);
    check_eq("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", pc_plus4, 32'h0);
    check_eq("wrap_addr1", bus.imem_addr, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    check_eq("mis_req", {31'd0, bus.imem_req}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("mis_sticky", {31'd0, fetch_misalign}, 32'd1);
    check_eq("mis_req_hold", {31'd0, bus.imem_req}, 32'd0);
    expect_bubble("mis");
`else
    redirect    = 1'b1;
    redirect_pc = 32'h22;
    @(negedge clk);
    check_eq("unalign_addr", bus.imem_addr, 32'h20);
    redirect = 1'b0;
    @(negedge clk);
    expect_live("unalign_word", 32'h20);
`endif

    // Reset in the middle of a waiting request.
    bus.imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("mid_rst_addr", bus.imem_addr, 32'h0);
    expect_bubble("mid_rst");
    @(negedge clk);
    rst_n          = 1'b1;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    check_eq("rerun_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("rerun_addr", bus.imem_addr, 32'h0);
    expect_bubble("rerun_gap");
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("mis_cleared", {31'd0, fetch_misalign}, 32'd0);
`endif
    @(negedge clk);
    expect_live("rerun_word", 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
